// File: rtl/axi_wdata_router.sv
// AXI W-channel router steered by an in-order queue of AW targets.
// Optional burst-length checking is enabled by defining AXI_WDATA_LEN_CHECK_EN.
module axi_wdata_router #(
  parameter int NUM_M  = 2,
  parameter int NUM_S  = 3,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int LEN_W  = 4,
  localparam int STRB_W = DATA_W / 8,
  localparam int MW = (NUM_M > 1) ? $clog2(NUM_M) : 1,
  localparam int SW = $clog2(NUM_S),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     aw_push_valid,
  input  logic [MW-1:0]            aw_push_mst,
  input  logic [SW-1:0]            aw_push_slv,
  input  logic [LEN_W-1:0]         aw_push_len,
  output logic                     aw_push_ready,
  input  logic [NUM_M*DATA_W-1:0]  m_wdata,
  input  logic [NUM_M*STRB_W-1:0]  m_wstrb,
  input  logic [NUM_M-1:0]         m_wlast,
  input  logic [NUM_M-1:0]         m_wvalid,
  output logic [NUM_M-1:0]         m_wready,
  output logic [DATA_W-1:0]        s_wdata,
  output logic [STRB_W-1:0]        s_wstrb,
  output logic                     s_wlast,
  output logic [NUM_S-1:0]         s_wvalid,
  input  logic [NUM_S-1:0]         s_wready,
  output logic [CW-1:0]            pending,
  output logic                     len_err
);

  localparam int PW = $clog2(DEPTH);

  logic [MW-1:0]    mst_q [DEPTH];
  logic [SW-1:0]    slv_q [DEPTH];
  logic [LEN_W-1:0] len_q [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt;

  logic [MW-1:0]    head_mst;
  logic [SW-1:0]    head_slv;
  logic [LEN_W-1:0] head_len;
  logic route, mv, sr, wlast_in, fire, push, pop;

  assign head_mst = mst_q[rd_ptr];
  assign head_slv = slv_q[rd_ptr];
  assign head_len = len_q[rd_ptr];

  // Out-of-range targets never match and stall until reset.
  assign route = (cnt != '0)
              && (int'(head_mst) < NUM_M)
              && (int'(head_slv) < NUM_S);

  always_comb begin
    mv       = 1'b0;
    sr       = 1'b0;
    wlast_in = 1'b0;
    s_wdata  = '0;
    s_wstrb  = '0;
    m_wready = '0;
    s_wvalid = '0;
    if (route) begin
      for (int i = 0; i < NUM_M; i++) begin
        if (head_mst == MW'(i)) begin
          mv       = m_wvalid[i];
          wlast_in = m_wlast[i];
          s_wdata  = m_wdata[i*DATA_W +: DATA_W];
          s_wstrb  = m_wstrb[i*STRB_W +: STRB_W];
        end
      end
      for (int j = 0; j < NUM_S; j++) begin
        if (head_slv == SW'(j)) sr = s_wready[j];
      end
      for (int i = 0; i < NUM_M; i++) begin
        if (head_mst == MW'(i)) m_wready[i] = sr;
      end
      for (int j = 0; j < NUM_S; j++) begin
        if (head_slv == SW'(j)) s_wvalid[j] = mv;
      end
    end
  end

  assign fire          = route && mv && sr;
  assign aw_push_ready = (cnt != CW'(DEPTH));
  assign push          = aw_push_valid && aw_push_ready;
  assign pending       = cnt;

`ifdef AXI_WDATA_LEN_CHECK_EN
  logic [LEN_W:0] bcnt;
  logic           last_beat;

  assign last_beat = (bcnt == {1'b0, head_len});
  assign s_wlast   = route && (wlast_in || last_beat);
  assign pop       = fire && last_beat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt    <= '0;
      len_err <= 1'b0;
    end else if (fire) begin
      bcnt <= last_beat ? '0 : bcnt + 1'b1;
      if (wlast_in != last_beat) len_err <= 1'b1;
    end
  end
`else
  logic unused_len;

  assign unused_len = ^head_len;
  assign s_wlast    = wlast_in;
  assign pop        = fire && wlast_in;
  assign len_err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      mst_q[wr_ptr] <= aw_push_mst;
      slv_q[wr_ptr] <= aw_push_slv;
      len_q[wr_ptr] <= aw_push_len;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule
